cur_fetch: RTL and testbench

- Transmit end of the current-block load path in the 4K/60fps motion-estimation core.
- On `start`, fetches one current block (BLK_ROWS x ROW_WORDS 32-bit words, row-major) from frame memory through a read port with variable latency.
- Buffers the returned words in a small prefetch FIFO.
- Streams them one word per cycle to the current-block buffer while that buffer holds its `en_in` request high.
- The current-block buffer packs word pairs into 64-bit SRAM rows; this block only delivers ordered 32-bit words and signals completion.

---
 rtl/cur_fetch.sv | 100 ++++++++++
 tb/tb_cur_fetch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cur_fetch.sv
// cur_fetch: fetches one current block from frame memory and streams its words in order to the block buffer
module cur_fetch #(
  parameter int AW = 24,
  parameter int BLK_ROWS = 16,
  parameter int ROW_WORDS = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] stride,
  output logic          busy,
  output logic          done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rdy,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  input  logic          en_in,
  output logic [31:0]   in_data,
  output logic          underrun
);
  localparam int N = BLK_ROWS * ROW_WORDS;
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 2;
  localparam int LW = $clog2(ROW_WORDS + 1);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;
  logic [31:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] cnt, cnt_nx, outst, out_nx;
  logic [CW-1:0] issued, issued_nx, delivered, delivered_nx;
  logic [LW-1:0] col;
  logic [AW-1:0] row_base, stride_q;
  logic idle, accept, push, want, pop, room, last_col;
  always_comb begin
    idle = state == S_IDLE;
    accept = mem_rd && mem_rdy;
    push = busy && mem_rvalid;
    want = busy && en_in && delivered != CW'(N);
    pop = want && cnt != '0;
    cnt_nx = idle ? '0 : cnt + (PW+1)'(push) - (PW+1)'(pop);
    out_nx = idle ? '0 : outst + (PW+1)'(accept) - (PW+1)'(push);
    issued_nx = idle ? '0 : issued + CW'(accept);
    delivered_nx = idle ? '0 : delivered + CW'(pop);
    room = OW'(cnt_nx) + OW'(out_nx) < OW'(FIFO_DEPTH);
    last_col = col == LW'(ROW_WORDS - 1);
    state_nx = idle ? (start ? S_FETCH : S_IDLE) :
               state == S_FETCH ? (issued == CW'(N) ? S_DRAIN : S_FETCH) :
               state == S_DRAIN ? (delivered == CW'(N) ? S_DONE : S_DRAIN) : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      mem_rd <= 1'b0;
      mem_addr <= '0;
      in_data <= '0;
      underrun <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      outst <= '0;
      issued <= '0;
      delivered <= '0;
      col <= '0;
      row_base <= '0;
      stride_q <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      outst <= out_nx;
      issued <= issued_nx;
      delivered <= delivered_nx;
      busy <= state_nx == S_FETCH || state_nx == S_DRAIN;
      done <= state_nx == S_DONE;
      mem_rd <= state_nx == S_FETCH && issued_nx != CW'(N) && room;
      underrun <= idle ? underrun && !start : underrun || (want && cnt == '0);
      if (idle && start) begin
        row_base <= base_addr;
        mem_addr <= base_addr;
        stride_q <= stride;
        col <= '0;
      end else if (accept) begin
        col <= last_col ? '0 : col + LW'(1);
        row_base <= last_col ? row_base + stride_q : row_base;
        mem_addr <= last_col ? row_base + stride_q : mem_addr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        in_data <= fifo[rd_ptr];
      end
    end
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= mem_rdata;
endmodule

// File: tb/tb_cur_fetch.sv
// tb_cur_fetch: directed self-checking bench for cur_fetch
module tb_cur_fetch;
  logic clk = 0, rst = 1, start = 0, mem_rdy = 1, mem_rvalid = 0, en_in = 0;
  logic [23:0] base_addr = 0, stride = 0;
  logic [31:0] mem_rdata = 0;
  logic busy, done, mem_rd, underrun;
  logic [23:0] mem_addr;
  logic [31:0] in_data;
  typedef struct {logic [23:0] addr; int due;} req_t;
  req_t q[$];
  req_t r;
  logic [23:0] addrs[$];
  logic [31:0] got[$];
  logic [31:0] prev_in = 0;
  logic [23:0] held = 0;
  logic [5:0] pat = 6'b001011;
  int jc = 0, lat = 2, en_mode = 0, ph = 0, done_cnt = 0, occ = 0, max_occ = 0, bad_rd = 0;
  int stall_left = 0, stall_bad = 0, total = 0, bad = 0;

  always #5 clk = ~clk;

  cur_fetch dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .en_in(en_in), .in_data(in_data),
    .underrun(underrun)
  );

  initial forever begin
    @(negedge clk);
    jc++;
    if (q.size() > 0 && q[0].due <= jc) begin
      mem_rvalid = 1;
      mem_rdata = {8'hC0, q[0].addr};
      q.delete(0);
    end else begin
      mem_rvalid = 0;
      mem_rdata = 32'hDEAD_BEEF;
    end
    if (in_data !== prev_in) begin
      got.push_back(in_data);
      prev_in = in_data;
    end
    done_cnt += int'(done);
    occ = addrs.size() - got.size();
    if (occ > max_occ) max_occ = occ;
    if (mem_rd && occ >= 4) bad_rd++;
    if (stall_left > 0 && addrs.size() == 2 && (mem_rd || stall_left < 5)) begin
      if (!mem_rd || (stall_left < 5 && mem_addr !== held)) stall_bad++;
      held = mem_addr;
      mem_rdy = 0;
      stall_left--;
    end else mem_rdy = 1;
    if (mem_rd && mem_rdy) begin
      r.addr = mem_addr;
      r.due = jc + lat;
      q.push_back(r);
      addrs.push_back(mem_addr);
    end
    en_in = (en_mode == 1) || (en_mode == 2 && pat[ph]);
    ph = ph == 5 ? 0 : ph + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ea(input logic [23:0] b, input logic [23:0] s, input int i);
    return b + s * 24'(i / 2) + 24'(i % 2);
  endfunction

  task automatic begin_block(input logic [23:0] b, input logic [23:0] s);
    addrs.delete();
    got.delete();
    done_cnt = 0;
    max_occ = 0;
    bad_rd = 0;
    base_addr = b;
    stride = s;
    start = 1;
    step();
    start = 0;
  endtask

  task automatic finish_block(input logic [23:0] b, input logic [23:0] s, input int exp_ur, input int extra);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      step();
      n++;
    end
    chk("done_seen", done_cnt != 0, 1);
    repeat (extra) step();
    chk("done_once", done_cnt, 1);
    chk("busy_low_at_done", busy, 0);
    chk("addr_count", addrs.size(), 32);
    for (int i = 0; i < addrs.size() && i < 32; i++) chk($sformatf("addr[%0d]", i), addrs[i], ea(b, s, i));
    chk("word_count", got.size(), 32);
    for (int i = 0; i < got.size() && i < 32; i++) chk($sformatf("word[%0d]", i), got[i], {8'hC0, ea(b, s, i)});
    chk("occ_le_depth", max_occ <= 4, 1);
    chk("rd_while_full", bad_rd, 0);
    if (exp_ur >= 0) chk("underrun", underrun, exp_ur[0]);
  endtask

  initial begin
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_in_data", in_data, 0);
    chk("rst_underrun", underrun, 0);
    rst = 0;
    step();
    lat = 6;
    en_mode = 1;
    begin_block(24'h001000, 24'h000100);
    step();
    chk("ur_first_en", underrun, 1);
    chk("hold_zero_a", in_data, 0);
    repeat (2) step();
    chk("hold_zero_b", in_data, 0);
    finish_block(24'h001000, 24'h000100, 1, 3);
    lat = 2;
    en_mode = 0;
    begin_block(24'h001000, 24'h000100);
    chk("ur_cleared", underrun, 0);
    repeat (3) step();
    en_mode = 1;
    finish_block(24'h001000, 24'h000100, 0, 3);
    lat = 1;
    en_mode = 2;
    begin_block(24'h000200, 24'h000040);
    finish_block(24'h000200, 24'h000040, -1, 3);
    chk("occ_peak", max_occ, 4);
    lat = 2;
    en_mode = 1;
    stall_left = 5;
    begin_block(24'h00F000, 24'h000010);
    finish_block(24'h00F000, 24'h000010, 1, 3);
    chk("stall_taken", stall_left, 0);
    chk("stall_stable", stall_bad, 0);
    begin_block(24'h002000, 24'h000080);
    repeat (9) step();
    base_addr = 24'hABCDEF;
    stride = 24'h000001;
    start = 1;
    step();
    start = 0;
    finish_block(24'h002000, 24'h000080, 1, 0);
    step();
    lat = 6;
    en_mode = 0;
    begin_block(24'h123400, 24'h000010);
    chk("restart_busy", busy, 1);
    for (int n = 0; n < 50 && addrs.size() < 3; n++) step();
    chk("busy_before_rst", busy, 1);
    rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_mem_rd", mem_rd, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_in_data", in_data, 0);
    chk("arst_underrun", underrun, 0);
    repeat (2) step();
    rst = 0;
    repeat (10) step();
    chk("late_busy", busy, 0);
    chk("late_mem_rd", mem_rd, 0);
    chk("late_in_data", in_data, 0);
    chk("late_no_done", done_cnt, 0);
    lat = 2;
    en_mode = 1;
    begin_block(24'h000000, 24'h000100);
    finish_block(24'h000000, 24'h000100, 1, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
